nrisc_fetch_unit: RTL and testbench

- Upstream neighbour of the instruction decoder: owns the program counter and fetches 16-bit instruction words from instruction memory.
- Delivers each word, tagged with its PC, through a 2-entry buffer over a valid/ready handshake; the word drives CORE_InstructionIN.
- Accepts redirects for sequential, absolute branch, relative branch and interrupt vector, and flushes stale fetches on every redirect.

---
 rtl/nrisc_fetch_unit_pkg.sv | 20 ++
 rtl/nrisc_fetch_buffer.sv | 67 ++++++
 rtl/nrisc_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_nrisc_fetch_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_fetch_unit_pkg.sv
// Shared definitions for the nRISC fetch unit: redirect modes, fetch FSM
// states and the global word/address widths.
package nrisc_fetch_unit_pkg;

  localparam int NRISC_TAM = 16;
  localparam int INSTR_W   = 16;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_ABS = 2'b01,
    PC_REL = 2'b10,
    PC_INT = 2'b11
  } pc_ctrl_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/nrisc_fetch_buffer.sv
// Two-entry FIFO of {instruction word, pc} between instruction memory and the
// decoder. Flush empties it in one cycle; a same-cycle pop is still honoured.
module nrisc_fetch_buffer
  import nrisc_fetch_unit_pkg::*;
#(
  parameter int TAM = NRISC_TAM
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] push_word_i,
  input  logic [TAM-1:0]     push_pc_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [INSTR_W-1:0] head_word_o,
  output logic [TAM-1:0]     head_pc_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [1:0]         count_o
);

  logic [INSTR_W-1:0] word_q [2];
  logic [TAM-1:0]     pc_q   [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         count_q;
  logic               push_ok;
  logic               pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign push_ok = push_i && !flush_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  assign head_word_o = word_q[rd_ptr_q];
  assign head_pc_o   = pc_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      word_q[0] <= '0;
      word_q[1] <= '0;
      pc_q[0]   <= '0;
      pc_q[1]   <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        word_q[wr_ptr_q] <= push_word_i;
        pc_q[wr_ptr_q]   <= push_pc_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/nrisc_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches 16-bit words from instruction
// memory and hands them, tagged with their PC, to the decoder.
module nrisc_fetch_unit
  import nrisc_fetch_unit_pkg::*;
#(
  parameter int             TAM          = NRISC_TAM,
  parameter logic [TAM-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [TAM-1:0]     imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               pc_load,
  input  logic [1:0]         pc_ctrl,
  input  logic [TAM-1:0]     pc_target,
  output logic [INSTR_W-1:0] instr_out,
  output logic [TAM-1:0]     instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [TAM-1:0]     epc
);

  localparam logic [TAM-1:0] PC_ONE = {{(TAM-1){1'b0}}, 1'b1};

  fetch_state_e   state_q, state_d;
  logic [TAM-1:0] addr_q, addr_d;
  logic [TAM-1:0] pend_q, pend_d;
  logic           drop_q, drop_d;
  logic [TAM-1:0] last_pc_q, last_pc_d;
  logic [TAM-1:0] epc_q, epc_d;

  logic           redirect;
  logic           pop;
  logic           ack_fire;
  logic           push;
  logic [TAM-1:0] base_pc;
  logic [TAM-1:0] target;
  logic [1:0]     count_nxt;
  logic           buf_full;
  logic           buf_empty;
  logic [1:0]     buf_count;

  assign redirect = pc_load && (pc_ctrl != PC_SEQ);
  assign pop      = instr_valid && instr_ready;
  assign ack_fire = (state_q == ST_REQ) && imem_ack;
  // Words answering a superseded request, or arriving with a redirect, are discarded.
  assign push     = ack_fire && !drop_q && !redirect;

  // Relative and interrupt redirects are based on the instruction consumed this cycle, if any.
  assign base_pc   = pop ? instr_pc : last_pc_q;
  assign count_nxt = redirect ? 2'd0 : (buf_count + {1'b0, push} - {1'b0, pop});

  always_comb begin
    target = pc_target;
    case (pc_ctrl)
      PC_REL:  target = base_pc + pc_target;
      default: target = pc_target;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pend_d    = pend_q;
    drop_d    = drop_q;
    last_pc_d = pop ? instr_pc : last_pc_q;
    epc_d     = (redirect && (pc_ctrl == PC_INT)) ? (base_pc + PC_ONE) : epc_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          addr_d = target;
        end
        if (!buf_full || pop || redirect) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_fire) begin
          if (redirect) begin
            addr_d = target;
          end else if (drop_q) begin
            addr_d = pend_q;
          end else begin
            addr_d = addr_q + PC_ONE;
          end
          drop_d  = 1'b0;
          state_d = (count_nxt == 2'd2) ? ST_IDLE : ST_REQ;
        end else if (redirect) begin
          // The outstanding request cannot be withdrawn; remember where to go once it returns.
          drop_d = 1'b1;
          pend_d = target;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= RESET_VECTOR;
      drop_q    <= 1'b0;
      last_pc_q <= RESET_VECTOR;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      drop_q    <= drop_d;
      last_pc_q <= last_pc_d;
      epc_q     <= epc_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  nrisc_fetch_buffer #(
    .TAM(TAM)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_word_i(imem_data),
    .push_pc_i  (addr_q),
    .pop_i      (pop),
    .flush_i    (redirect),
    .head_word_o(instr_out),
    .head_pc_o  (instr_pc),
    .full_o     (buf_full),
    .empty_o    (buf_empty),
    .count_o    (buf_count)
  );

  assign instr_valid = !buf_empty;
  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = addr_q;
  assign epc         = epc_q;

endmodule

// File: tb/tb_nrisc_fetch_unit.sv
// Directed bench for nrisc_fetch_unit with a variable-latency memory model
// whose data word is the address XOR 16'hA5A5.
module tb_nrisc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        pc_load;
  logic [1:0]  pc_ctrl;
  logic [15:0] pc_target;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] epc;

  logic [7:0]  lat;
  logic [7:0]  wcnt;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  nrisc_fetch_unit #(
    .TAM         (16),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .pc_load    (pc_load),
    .pc_ctrl    (pc_ctrl),
    .pc_target  (pc_target),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .epc        (epc)
  );

  // Memory: acknowledges after the request has been held for lat cycles.
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 8'd0;
    else                       wcnt <= wcnt + 8'd1;
  end
  assign imem_ack  = imem_req && (wcnt >= lat);
  assign imem_data = imem_addr ^ 16'hA5A5;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input string tag, input logic [15:0] pc, input int budget);
    logic found;
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (instr_valid && instr_pc == pc) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic redirect(input logic [1:0] mode, input logic [15:0] tgt);
    pc_load   = 1'b1;
    pc_ctrl   = mode;
    pc_target = tgt;
    tick();
    pc_load   = 1'b0;
    pc_ctrl   = 2'b00;
  endtask

  initial begin
    logic found;
    int   held;
    rst = 1'b1; pc_load = 1'b0; pc_ctrl = 2'b00; pc_target = 16'h0000;
    instr_ready = 1'b1; lat = 8'd0;
    tick(); tick();
    chk("rst_req",  imem_req,    0);
    chk("rst_addr", imem_addr,   16'h0000);
    chk("rst_vld",  instr_valid, 0);
    chk("rst_out",  instr_out,   16'h0000);
    chk("rst_pc",   instr_pc,    16'h0000);
    chk("rst_epc",  epc,         16'h0000);

    // Zero-wait sequential fetch
    rst = 1'b0;
    tick();
    chk("seq_req0",  imem_req,    1);
    chk("seq_addr0", imem_addr,   16'h0000);
    chk("seq_vld0",  instr_valid, 0);
    tick();
    chk("seq_vld1",  instr_valid, 1);
    chk("seq_out0",  instr_out,   16'hA5A5);
    chk("seq_pc0",   instr_pc,    16'h0000);
    chk("seq_addr1", imem_addr,   16'h0001);
    tick();
    chk("seq_out1",  instr_out,   16'hA5A4);
    chk("seq_pc1",   instr_pc,    16'h0001);
    tick();
    chk("seq_out2",  instr_out,   16'hA5A7);
    chk("seq_pc2",   instr_pc,    16'h0002);
    redirect(2'b00, 16'h0040);
    chk("noop_pc",   instr_pc,    16'h0003);
    chk("noop_vld",  instr_valid, 1);

    // Back-pressure from the decoder
    rst = 1'b1; instr_ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("bp_req",  imem_req,    0);
    chk("bp_vld",  instr_valid, 1);
    chk("bp_pc",   instr_pc,    16'h0000);
    chk("bp_out",  instr_out,   16'hA5A5);
    instr_ready = 1'b1;
    tick();
    chk("bp_req1",  imem_req,  1);
    chk("bp_addr2", imem_addr, 16'h0002);
    chk("bp_pc1",   instr_pc,  16'h0001);
    chk("bp_out1",  instr_out, 16'hA5A4);
    tick();
    chk("bp_pc2",   instr_pc,  16'h0002);
    chk("bp_addr3", imem_addr, 16'h0003);

    // Absolute redirect against an outstanding slow request
    lat = 8'd3;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (imem_req && imem_addr == 16'h0005) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("abs_reach", {31'd0, found}, 32'd1);
    redirect(2'b01, 16'h0040);
    chk("abs_addr5", imem_addr,   16'h0005);
    chk("abs_req",   imem_req,    1);
    chk("abs_flush", instr_valid, 0);
    held = 0;
    for (int k = 0; k < 10; k++) begin
      if (imem_addr != 16'h0005) break;
      held++;
      tick();
    end
    chk("abs_held",  held,        3);
    chk("abs_addr",  imem_addr,   16'h0040);
    chk("abs_drop",  instr_valid, 0);
    wait_pc("abs_to", 16'h0040, 20);
    chk("abs_out",   instr_out,   16'hA5E5);

    // Relative redirect on the pop of 0x0010
    lat = 8'd0;
    redirect(2'b01, 16'h000C);
    wait_pc("rel_to", 16'h0010, 30);
    redirect(2'b10, 16'hFFFE);
    chk("rel_flush", instr_valid, 0);
    chk("rel_addr",  imem_addr,   16'h000E);
    tick();
    chk("rel_vld",   instr_valid, 1);
    chk("rel_pc",    instr_pc,    16'h000E);
    chk("rel_out",   instr_out,   16'hA5AB);

    // Interrupt redirect after consuming 0x0023
    redirect(2'b01, 16'h0020);
    wait_pc("int_to", 16'h0023, 30);
    redirect(2'b11, 16'h0100);
    chk("int_epc",   epc,         16'h0024);
    tick();
    chk("int_pc",    instr_pc,    16'h0100);
    chk("int_out",   instr_out,   16'hA4A5);

    // Address wrap
    redirect(2'b01, 16'hFFFF);
    chk("wrap_addr_ff", imem_addr,   16'hFFFF);
    tick();
    chk("wrap_addr_0",  imem_addr,   16'h0000);
    chk("wrap_vld",     instr_valid, 1);
    chk("wrap_pc_ff",   instr_pc,    16'hFFFF);
    chk("wrap_out_ff",  instr_out,   16'h5A5A);
    tick();
    chk("wrap_pc_0",    instr_pc,    16'h0000);
    chk("wrap_out_0",   instr_out,   16'hA5A5);

    // Reset during an active request
    chk("mid_req_pre", imem_req, 1);
    rst = 1'b1;
    tick();
    chk("mid_req",  imem_req,    0);
    chk("mid_vld",  instr_valid, 0);
    chk("mid_addr", imem_addr,   16'h0000);
    chk("mid_epc",  epc,         16'h0000);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
